// File: rtl/mem_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_responder
// Description : Memory-side responder for cache fills. Accepts one read or
//               write per cycle on a 16-bit byte address. Reads are fully
//               pipelined and return exactly LATENCY cycles after issue with
//               a one-cycle data_valid strobe; writes update the word array
//               at the sampling edge and produce no response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_responder #(
    parameter int unsigned LATENCY    = 4,   // 1..8
    parameter int unsigned ADDR_WIDTH = 15   // word-index width, up to 15
) (
    input  logic        clk,
    input  logic        rst_n,      // asynchronous, active-high despite the name
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  pending,
    output logic        busy
);

    localparam int unsigned c_depth = 1 << ADDR_WIDTH;
    // Byte-address bits that form the word index (bit 0 is the byte lane).
    localparam logic [15:0] c_idx_mask = 16'(((32'd1 << ADDR_WIDTH) - 32'd1) << 1);

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_unused_addr;

    // Backing word array; deliberately never reset.
    logic [15:0]           r_mem [c_depth];

    // In-flight read pipeline: stage 0 is loaded at the issue edge, the last
    // stage feeds the output register on the following edge, which gives the
    // LATENCY-edge issue-to-return distance.
    logic [LATENCY-1:0]    r_vld;
    logic [15:0]           r_dat [LATENCY];

    logic                  r_dv;
    logic [15:0]           r_dout;
    logic [3:0]            r_pending;

    assign w_idx = addr[ADDR_WIDTH:1];
    assign w_rd  = enable & ~wr;
    assign w_wr  = enable & wr;

    // Byte-lane bit and any address bits above the word index are ignored.
    assign w_unused_addr = ^(addr & ~c_idx_mask);

    // Array write on the sampling edge of a write request.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Data half of the pipeline: capture the pre-edge array word, then shift.
    // Only meaningful alongside the matching valid bit, so no reset needed.
    always_ff @(posedge clk) begin
        r_dat[0] <= r_mem[w_idx];
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_dat[i] <= r_dat[i-1];
        end
    end

    // Valid bits, output register and in-flight count; reset drops all reads.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_vld     <= '0;
            r_dv      <= 1'b0;
            r_dout    <= 16'h0000;
            r_pending <= 4'd0;
        end else begin
            r_vld[0] <= w_rd;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_dv      <= r_vld[LATENCY-1];
            r_dout    <= r_vld[LATENCY-1] ? r_dat[LATENCY-1] : 16'h0000;
            // A read issuing and a read retiring on the same edge cancel out.
            r_pending <= r_pending + {3'b000, w_rd} - {3'b000, r_vld[LATENCY-1]};
        end
    end

    assign data_out   = r_dout;
    assign data_valid = r_dv;
    assign pending    = r_pending;
    assign busy       = (r_pending != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_mem_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_responder
// Description : Self-checking bench for mem_read_responder. Directed vector
//               table, hand-written burst/reset sequences and a randomized
//               phase checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_read_responder #(.LATENCY(L), .ADDR_WIDTH(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each read is remembered with its issue edge and the word it must return;
    // it comes back exactly L edges later. Pending is the queue length.
    typedef struct {
        int unsigned e;
        logic [15:0] d;
    } rsp_t;

    rsp_t        q[$];
    logic [15:0] mm [int];
    int unsigned edge_n = 0;
    logic        exp_dv = 1'b0;
    logic [15:0] exp_dout = 16'h0000;
    logic [3:0]  exp_pend = 4'd0;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        dv;
        logic [15:0] dout;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic en_i, logic wr_i, logic [15:0] a, logic [15:0] d,
                               logic dv_i, logic [15:0] dout_i, logic [3:0] p);
        vec_t t;
        t.en = en_i; t.wr = wr_i; t.addr = a; t.din = d;
        t.dv = dv_i; t.dout = dout_i; t.pend = p;
        return t;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(string nm, logic dv, logic [15:0] d, logic [3:0] p);
        chk({nm, ".dv"},   {15'd0, data_valid}, {15'd0, dv});
        chk({nm, ".dout"}, data_out, d);
        chk({nm, ".pend"}, {12'd0, pending}, {12'd0, p});
        chk({nm, ".busy"}, {15'd0, busy}, {15'd0, (p != 4'd0)});
    endtask

    // Apply one request across one rising edge, update the model, sample #1 later.
    task automatic drive(logic en_i, logic wr_i, logic [15:0] a, logic [15:0] d);
        int k;
        enable = en_i; wr = wr_i; addr = a; data_in = d;
        @(posedge clk);
        edge_n++;
        k = int'(a[15:1]);
        if (rst_n) begin
            q.delete();
        end else if (en_i && !wr_i) begin
            q.push_back('{edge_n, (mm.exists(k) ? mm[k] : 16'hxxxx)});
        end
        if (en_i && wr_i) mm[k] = d;
        exp_dv = 1'b0;
        exp_dout = 16'h0000;
        if (q.size() > 0 && q[0].e + L == edge_n) begin
            exp_dv = 1'b1;
            exp_dout = q[0].d;
            void'(q.pop_front());
        end
        exp_pend = 4'(q.size());
        #1;
    endtask

    initial begin
        int peak;
        logic dv_e;
        logic [15:0] d_e;
        int p_e;
        int iss;
        int ret;

        // Reset held two cycles with enable toggling.
        for (int c = 0; c < 2; c++) begin
            drive((c == 0), 1'b0, 16'h0040, 16'h0000);
            chk_out("rst_hold", 1'b0, 16'h0000, 4'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;

        // Directed vectors: single read, enable=0 write ignored, hazards, odd bit.
        tbl.push_back(v(1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000, 0));
        tbl.push_back(v(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0));
        tbl.push_back(v(0, 1, 16'h0040, 16'hDEAD, 0, 16'h0000, 0));
        tbl.push_back(v(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0));
        tbl.push_back(v(1, 1, 16'h0200, 16'h1111, 0, 16'h0000, 0));
        tbl.push_back(v(1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 16'h0200, 16'h2222, 0, 16'h0000, 1));
        tbl.push_back(v(1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 2));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 2));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h2222, 0));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
        tbl.push_back(v(1, 1, 16'h0003, 16'hA5A5, 0, 16'h0000, 0));
        tbl.push_back(v(1, 0, 16'h0002, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0));
        tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].dv, tbl[i].dout, tbl[i].pend);
        end

        // Line fill burst: preload, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'(16'h0120 + 2 * i), 16'(16'h1000 + i));
        end
        peak = 0;
        for (int j = 0; j < 12; j++) begin
            drive((j < 8), 1'b0, 16'(16'h0120 + 2 * (j % 8)), 16'h0000);
            iss  = (j + 1 < 8) ? j + 1 : 8;
            ret  = (j - 3 < 0) ? 0 : ((j - 3 > 8) ? 8 : j - 3);
            p_e  = iss - ret;
            dv_e = (j >= L) && (j < L + 8);
            d_e  = dv_e ? 16'(16'h1000 + j - L) : 16'h0000;
            chk_out($sformatf("burst[%0d]", j), dv_e, d_e, 4'(p_e));
            if (int'(pending) > peak) peak = int'(pending);
        end
        chk("burst.peak", 16'(peak), 16'd4);

        // Reset mid-burst while a beat is on the output.
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 16'(16'h0120 + 2 * j), 16'h0000);
        end
        chk_out("pre_rst", 1'b1, 16'h1000, 4'd4);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 16'h0000, 4'd0);
        q.delete();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_out("rst_edge", 1'b0, 16'h0000, 4'd0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk_out($sformatf("no_stale[%0d]", j), 1'b0, 16'h0000, 4'd0);
        end
        drive(1'b1, 1'b0, 16'h0126, 16'h0000);
        chk_out("post_rst_issue", 1'b0, 16'h0000, 4'd1);
        for (int j = 1; j <= L; j++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk_out($sformatf("post_rst[%0d]", j), (j == L), (j == L) ? 16'h1003 : 16'h0000,
                    (j == L) ? 4'd0 : 4'd1);
        end

        // Randomized traffic on a small window so hazards are frequent.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 16'(i * 2), 16'($urandom));
        end
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  {10'd0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))},
                  16'($urandom));
            chk_out($sformatf("rand[%0d]", i), exp_dv, exp_dout, exp_pend);
        end
        for (int i = 0; i < L + 1; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk_out($sformatf("drain[%0d]", i), exp_dv, exp_dout, exp_pend);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
